// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests, sequences jump/interrupt redirects
// and debug halt, and drives the per-stage stall vector, flush pulse and PC redirect.
module pipe_ctrl #(
   parameter int STALL_TIMEOUT = 1024,
   parameter int STALL_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_stall_req_i,
   input  logic                   ex_stall_req_i,
   input  logic                   mem_stall_req_i,
   input  logic                   jump_req_i,
   input  logic [31:0]            jump_addr_i,
   input  logic                   int_req_i,
   input  logic [31:0]            int_addr_i,
   input  logic                   dbg_halt_req_i,
   output logic [STALL_WIDTH-1:0] stall_o,
   output logic                   flush_o,
   output logic                   redirect_o,
   output logic [31:0]            redirect_addr_o,
   output logic                   dbg_halted_o,
   output logic                   stall_timeout_o
);

   localparam int STALL_PC = 0;
   localparam int STALL_IF = 1;
   localparam int STALL_ID = 2;
   localparam int STALL_EX = 3;
   localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(STALL_TIMEOUT);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   state_e        state_q, state_d;
   logic          pend_vld_q, pend_vld_d;
   logic          pend_int_q, pend_int_d;
   logic [31:0]   pend_addr_q, pend_addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   logic                   new_req, sel_vld, issue, issue_ok;
   logic [31:0]            sel_addr;
   logic [STALL_WIDTH-1:0] stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pend_vld_q  <= 1'b0;
         pend_int_q  <= 1'b0;
         pend_addr_q <= '0;
         cnt_q       <= '0;
         to_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         pend_int_q  <= pend_int_d;
         pend_addr_q <= pend_addr_d;
         cnt_q       <= cnt_d;
         to_q        <= to_d;
      end
   end

   // Redirect selection: new int > pending int > new jump > pending jump.
   always_comb begin
      new_req  = int_req_i | jump_req_i;
      sel_vld  = new_req | pend_vld_q;
      sel_addr = pend_addr_q;
      if (int_req_i)                    sel_addr = int_addr_i;
      else if (pend_vld_q && pend_int_q) sel_addr = pend_addr_q;
      else if (jump_req_i)              sel_addr = jump_addr_i;
      issue_ok = !mem_stall_req_i && (state_q == RUN || state_q == DRAIN);
      issue    = issue_ok && sel_vld;
   end

   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_int_d  = pend_int_q;
      pend_addr_d = pend_addr_q;
      if (issue) begin
         pend_vld_d = 1'b0;
         pend_int_d = 1'b0;
      end else if (int_req_i) begin
         pend_vld_d  = 1'b1;
         pend_int_d  = 1'b1;
         pend_addr_d = int_addr_i;
      end else if (jump_req_i && state_q != HALTED && !(pend_vld_q && pend_int_q)) begin
         pend_vld_d  = 1'b1;
         pend_int_d  = 1'b0;
         pend_addr_d = jump_addr_i;
      end
   end

   always_comb begin
      stall = '0;
      if (mem_stall_req_i) stall = '1;
      if (ex_stall_req_i) begin
         stall[STALL_PC] = 1'b1;
         stall[STALL_IF] = 1'b1;
         stall[STALL_ID] = 1'b1;
      end
      if (fetch_stall_req_i) stall[STALL_PC] = 1'b1;
      if (state_q == DRAIN) begin
         stall[STALL_PC] = 1'b1;
         stall[STALL_IF] = 1'b1;
      end
      if (state_q == HALTED) stall = '1;
      if (issue) stall[STALL_PC] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:    if (dbg_halt_req_i) state_d = DRAIN;
         DRAIN: begin
            if (!dbg_halt_req_i) state_d = RUN;
            else if (!ex_stall_req_i && !mem_stall_req_i && !pend_vld_q && !new_req)
               state_d = HALTED;
         end
         HALTED: if (!dbg_halt_req_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      cnt_d = '0;
      to_d  = to_q;
      if (STALL_TIMEOUT > 0) begin
         if (state_q == RUN && stall[STALL_PC])
            cnt_d = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CW'(1);
         if (cnt_d == TO_VAL) to_d = 1'b1;
      end
   end

   // All outputs are held at zero while reset is asserted, independent of inputs.
   always_comb begin
      stall_o         = rst ? '0 : stall;
      redirect_o      = !rst && issue;
      flush_o         = !rst && issue;
      redirect_addr_o = (!rst && issue) ? sel_addr : 32'h0;
      dbg_halted_o    = !rst && (state_q == HALTED);
      stall_timeout_o = !rst && to_q;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl (STALL_TIMEOUT=8), checks sampled at negedge.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_stall, ex_stall, mem_stall, jump_req, int_req, halt_req;
   logic [31:0] jump_addr, int_addr;
   logic [3:0]  stall;
   logic        flush, redirect, halted, timeout;
   logic [31:0] raddr;
   int nvec = 0;
   int nerr = 0;
   int nredir;

   pipe_ctrl #(.STALL_TIMEOUT(8), .STALL_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .fetch_stall_req_i(fetch_stall), .ex_stall_req_i(ex_stall), .mem_stall_req_i(mem_stall),
      .jump_req_i(jump_req), .jump_addr_i(jump_addr),
      .int_req_i(int_req), .int_addr_i(int_addr), .dbg_halt_req_i(halt_req),
      .stall_o(stall), .flush_o(flush), .redirect_o(redirect), .redirect_addr_o(raddr),
      .dbg_halted_o(halted), .stall_timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Check all redirect-related outputs at negedge of the current cycle.
   task automatic chk_cyc(input string tag, input logic [3:0] e_stall, input logic e_redir,
                          input logic [31:0] e_addr, input logic e_halt);
      @(negedge clk);
      chk({tag, ".stall"}, 64'(stall), 64'(e_stall));
      chk({tag, ".redir"}, 64'(redirect), 64'(e_redir));
      chk({tag, ".flush"}, 64'(flush), 64'(e_redir));
      chk({tag, ".addr"}, 64'(raddr), 64'(e_addr));
      chk({tag, ".halted"}, 64'(halted), 64'(e_halt));
   endtask

   task automatic step();
      @(posedge clk); #1;
      jump_req = 1'b0; int_req = 1'b0;
   endtask

   task automatic idle();
      fetch_stall = 0; ex_stall = 0; mem_stall = 0; jump_req = 0; int_req = 0; halt_req = 0;
      jump_addr = 32'h0; int_addr = 32'h0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Outputs forced low during reset even with active inputs
      mem_stall = 1; jump_req = 1; jump_addr = 32'h1234; halt_req = 1;
      chk_cyc("rst_busy", 4'h0, 0, 32'h0, 0);
      chk("rst_to", 64'(timeout), 64'h0);
      step(); idle();
      rst = 1'b0;
      chk_cyc("idle", 4'h0, 0, 32'h0, 0);
      chk("idle_to", 64'(timeout), 64'h0);
      step();

      // Single-cycle jump, no stall
      jump_req = 1; jump_addr = 32'h100;
      chk_cyc("jmp", 4'h0, 1, 32'h100, 0);
      step();
      chk_cyc("jmp_after", 4'h0, 0, 32'h0, 0);
      step();

      // Jump held through mem_stall, issued on first free cycle
      for (int c = 0; c < 7; c++) begin
         mem_stall = (c < 5);
         if (c == 1) begin jump_req = 1; jump_addr = 32'h200; end
         if (c < 5)       chk_cyc($sformatf("hold%0d", c), 4'hF, 0, 32'h0, 0);
         else if (c == 5) chk_cyc("hold_iss", 4'h0, 1, 32'h200, 0);
         else             chk_cyc("hold_end", 4'h0, 0, 32'h0, 0);
         step();
      end

      // Pending jump overwritten by later int: exactly one redirect
      nredir = 0;
      for (int c = 0; c < 7; c++) begin
         mem_stall = (c < 5);
         if (c == 1) begin jump_req = 1; jump_addr = 32'h200; end
         if (c == 3) begin int_req = 1; int_addr = 32'h8000_0000; end
         @(negedge clk);
         if (redirect) nredir++;
         if (c == 5) chk("ovr_addr", 64'(raddr), 64'h8000_0000);
         step();
      end
      chk("ovr_count", 64'(nredir), 64'd1);

      // Pending int not overwritten by later jump
      mem_stall = 1; int_req = 1; int_addr = 32'h300;
      step();
      jump_req = 1; jump_addr = 32'h400;
      chk_cyc("pint_jmp", 4'hF, 0, 32'h0, 0);
      step();
      mem_stall = 0;
      chk_cyc("pint_iss", 4'h0, 1, 32'h300, 0);
      step();

      // Same-cycle int and jump: int wins
      jump_req = 1; jump_addr = 32'h500; int_req = 1; int_addr = 32'h600;
      chk_cyc("prio", 4'h0, 1, 32'h600, 0);
      step();
      chk_cyc("prio_end", 4'h0, 0, 32'h0, 0);
      step();

      // Debug halt: RUN, DRAIN x3, HALTED; int latched while halted, issued on resume
      halt_req = 1; ex_stall = 1;
      chk_cyc("h_run", 4'h7, 0, 32'h0, 0);
      step();
      chk_cyc("h_drain1", 4'h7, 0, 32'h0, 0);
      step();
      chk_cyc("h_drain2", 4'h7, 0, 32'h0, 0);
      step();
      ex_stall = 0;
      chk_cyc("h_drain3", 4'h3, 0, 32'h0, 0);
      step();
      chk_cyc("h_halted", 4'hF, 0, 32'h0, 1);
      step();
      int_req = 1; int_addr = 32'h80;
      chk_cyc("h_int", 4'hF, 0, 32'h0, 1);
      step();
      halt_req = 0;
      chk_cyc("h_rel", 4'hF, 0, 32'h0, 1);
      step();
      chk_cyc("h_resume", 4'h0, 1, 32'h80, 0);
      step();
      chk_cyc("h_done", 4'h0, 0, 32'h0, 0);
      step();

      // Watchdog: 8 consecutive PC-stall cycles set sticky flag
      fetch_stall = 1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("wd_pre%0d", c), 64'(timeout), 64'h0);
         chk($sformatf("wd_stall%0d", c), 64'(stall), 64'h1);
         step();
      end
      fetch_stall = 0;
      @(negedge clk);
      chk("wd_set", 64'(timeout), 64'h1);
      step(); step(); step();
      @(negedge clk);
      chk("wd_sticky", 64'(timeout), 64'h1);

      // Reset with a pending jump discards it and clears watchdog
      mem_stall = 1; jump_req = 1; jump_addr = 32'h700;
      step();
      rst = 1;
      step();
      rst = 0; mem_stall = 0;
      chk_cyc("rst_pend", 4'h0, 0, 32'h0, 0);
      chk("rst_wd", 64'(timeout), 64'h0);
      step();

      // Reset while HALTED returns to RUN
      halt_req = 1;
      step(); step();
      chk_cyc("rh_halted", 4'hF, 0, 32'h0, 1);
      rst = 1;
      step();
      rst = 0; halt_req = 0;
      chk_cyc("rh_run", 4'h0, 0, 32'h0, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
